// File: rtl/ahb_uart_pkg.sv
// Shared types and constants for the AHB-to-UART byte-stream bridge.
package ahb_uart_pkg;

   typedef enum logic [2:0] {IDLE, WAIT_TX, PUSH, WAIT_RX, RESP, GAP} ahb_uart_state_t;

   localparam logic [1:0] REG_DATA   = 2'd0;
   localparam logic [1:0] REG_STATUS = 2'd1;
   localparam logic [1:0] REG_CTRL   = 2'd2;

   localparam int ST_TX_FULL  = 0;
   localparam int ST_TX_EMPTY = 1;
   localparam int ST_RX_FULL  = 2;
   localparam int ST_RX_EMPTY = 3;
   localparam int ST_RX_OVF   = 4;

   localparam int CTRL_TX_EN       = 0;
   localparam int CTRL_RX_EN       = 1;
   localparam int CTRL_RX_BLOCK    = 2;
   localparam int CTRL_TX_EMPTY_IE = 3;
   localparam int CTRL_RX_AVAIL_IE = 4;
   localparam int CTRL_OVF_IE      = 5;
   localparam int CTRL_W           = 6;

   localparam logic [31:0] RX_EMPTY_WORD = 32'h8000_0000;

   typedef struct packed {
      logic        wr;
      logic [1:0]  idx;
      logic [2:0]  size;
      logic [31:0] wdata;
   } ahb_uart_req_t;

   function automatic logic [2:0] size_bytes(input logic [1:0] sz);
      return 3'd1 << sz;
   endfunction

endpackage

// File: rtl/ahb_uart_bridge_if.sv
// AHB slave-side transfer signals of the UART bridge.
interface ahb_uart_bridge_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic              hsel;
   logic              hwrite;
   logic [ADDR_W-1:0] haddr;
   logic [2:0]        hsize;
   logic [DATA_W-1:0] hwdata;
   logic [DATA_W-1:0] hrdata;
   logic              hready;
   logic              hresp;

   modport master (output hsel, hwrite, haddr, hsize, hwdata,
                   input  hrdata, hready, hresp);
   modport slave  (input  hsel, hwrite, haddr, hsize, hwdata,
                   output hrdata, hready, hresp);
endinterface

// File: rtl/ahb_uart_bridge_fifo.sv
// byte_fifo: power-of-2 byte FIFO with show-ahead head (0x00 when empty).
module byte_fifo #(
   parameter int DEPTH = 16,
   parameter int LW    = $clog2(DEPTH) + 1
) (
   input  logic          clk,
   input  logic          rstn,
   input  logic          push_i,
   input  logic          pop_i,
   input  logic [7:0]    din_i,
   output logic [7:0]    dout_o,
   output logic [LW-1:0] level_o,
   output logic          full_o,
   output logic          empty_o
);
   localparam int AW = $clog2(DEPTH);

   logic [7:0]    mem_q [DEPTH];
   logic [AW-1:0] wr_q, rd_q;
   logic [LW-1:0] lvl_q;

   // Caller only pushes when not full or when popping in the same cycle.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wr_q  <= '0;
         rd_q  <= '0;
         lvl_q <= '0;
      end else begin
         if (push_i) wr_q <= wr_q + 1'b1;
         if (pop_i)  rd_q <= rd_q + 1'b1;
         case ({push_i, pop_i})
            2'b10:   lvl_q <= lvl_q + 1'b1;
            2'b01:   lvl_q <= lvl_q - 1'b1;
            default: lvl_q <= lvl_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push_i) mem_q[wr_q] <= din_i;
   end

   assign empty_o = (lvl_q == '0);
   assign full_o  = (lvl_q == LW'(DEPTH));
   assign level_o = lvl_q;
   assign dout_o  = empty_o ? 8'h00 : mem_q[rd_q];
endmodule

// File: rtl/ahb_uart_bridge.sv
// AHB slave to UART byte-stream bridge with TX/RX byte FIFOs and CTRL/STATUS regs.
// Define AHB_UART_IRQ_EN to add the irq_o output and CTRL interrupt-enable bits.
module ahb_uart_bridge
   import ahb_uart_pkg::*;
#(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 32,
   parameter int TX_DEPTH = 16,
   parameter int RX_DEPTH = 16
) (
   input  logic       clk,
   input  logic       rstn,
   ahb_uart_bridge_if.slave bus,
   output logic       tx_valid_o,
   output logic [7:0] tx_data_o,
   input  logic       tx_ready_i,
   input  logic       rx_valid_i,
   input  logic [7:0] rx_data_i,
   output logic       rx_ready_o
`ifdef AHB_UART_IRQ_EN
   ,
   output logic       irq_o
`endif
);
   localparam int TLW = $clog2(TX_DEPTH) + 1;
   localparam int RLW = $clog2(RX_DEPTH) + 1;
`ifdef AHB_UART_IRQ_EN
   localparam logic [CTRL_W-1:0] CTRL_MASK = 6'h3F;
`else
   localparam logic [CTRL_W-1:0] CTRL_MASK = 6'h07;
`endif

   ahb_uart_state_t   state_q, state_d;
   ahb_uart_req_t     req_q, req_d;
   logic [1:0]        cnt_q, cnt_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic              err_q, err_d;
   logic              rd_empty_q, rd_empty_d;
   logic [CTRL_W-1:0] ctrl_q;
   logic              rx_ovf_q;

   logic           tx_push, tx_pop, tx_full, tx_empty;
   logic           rx_push, rx_pop, rx_full, rx_empty, ovf_set, reg_wr;
   logic [7:0]     tx_head, rx_head;
   logic [TLW-1:0] tx_level, tx_free;
   logic [RLW-1:0] rx_level;
   logic [31:0]    status_w;
   logic           unused_haddr;

   assign unused_haddr = ^{bus.haddr[ADDR_W-1:4], bus.haddr[1:0]};

   byte_fifo #(.DEPTH(TX_DEPTH)) u_tx_fifo (
      .clk, .rstn, .push_i(tx_push), .pop_i(tx_pop),
      .din_i(req_q.wdata[{cnt_q, 3'b000} +: 8]), .dout_o(tx_head),
      .level_o(tx_level), .full_o(tx_full), .empty_o(tx_empty)
   );

   byte_fifo #(.DEPTH(RX_DEPTH)) u_rx_fifo (
      .clk, .rstn, .push_i(rx_push), .pop_i(rx_pop), .din_i(rx_data_i),
      .dout_o(rx_head), .level_o(rx_level), .full_o(rx_full), .empty_o(rx_empty)
   );

   assign tx_free    = TLW'(TX_DEPTH) - tx_level;
   assign tx_valid_o = ctrl_q[CTRL_TX_EN] & ~tx_empty;
   assign tx_data_o  = tx_head;
   assign tx_pop     = tx_valid_o & tx_ready_i;

   assign reg_wr  = (state_q == RESP) & req_q.wr & ~err_q;
   assign rx_pop  = (state_q == RESP) & ~req_q.wr & ~err_q & (req_q.idx == REG_DATA) & ~rd_empty_q;
   // A pop in the same cycle frees a slot, so a full FIFO still takes the byte.
   assign rx_push = rx_valid_i & ctrl_q[CTRL_RX_EN] & (~rx_full | rx_pop);
   assign ovf_set = rx_valid_i & ctrl_q[CTRL_RX_EN] & rx_full & ~rx_pop;
   assign rx_ready_o = ctrl_q[CTRL_RX_EN];

   assign status_w = {8'h00, 8'(rx_level), 8'(tx_level), 3'b000,
                      rx_ovf_q, rx_empty, rx_full, tx_empty, tx_full};

   function automatic logic [31:0] rd_mux(input logic [1:0] idx);
      case (idx)
         REG_DATA:   return {24'h0, rx_head};
         REG_STATUS: return status_w;
         REG_CTRL:   return {{(32-CTRL_W){1'b0}}, ctrl_q};
         default:    return 32'h0;
      endcase
   endfunction

   always_comb begin
      state_d    = state_q;
      req_d      = req_q;
      cnt_d      = cnt_q;
      rdata_d    = rdata_q;
      err_d      = err_q;
      rd_empty_d = rd_empty_q;
      tx_push    = 1'b0;
      case (state_q)
         IDLE: if (bus.hsel) begin
            req_d      = '{wr: bus.hwrite, idx: bus.haddr[3:2], size: bus.hsize, wdata: bus.hwdata};
            err_d      = (bus.hsize > 3'd2);
            rd_empty_d = 1'b0;
            cnt_d      = 2'd0;
            if (bus.hsize > 3'd2)
               state_d = RESP;
            else if (bus.hwrite && bus.haddr[3:2] == REG_DATA)
               // Skip the hold when space is already there to meet n+1 latency.
               state_d = (tx_free >= TLW'(size_bytes(bus.hsize[1:0]))) ? PUSH : WAIT_TX;
            else if (!bus.hwrite && bus.haddr[3:2] == REG_DATA && rx_empty) begin
               if (ctrl_q[CTRL_RX_BLOCK]) state_d = WAIT_RX;
               else begin
                  rd_empty_d = 1'b1;
                  rdata_d    = RX_EMPTY_WORD;
                  state_d    = RESP;
               end
            end else begin
               if (!bus.hwrite) rdata_d = rd_mux(bus.haddr[3:2]);
               state_d = RESP;
            end
         end
         WAIT_TX: if (tx_free >= TLW'(size_bytes(req_q.size[1:0]))) state_d = PUSH;
         PUSH: begin
            tx_push = 1'b1;
            if (cnt_q == 2'(size_bytes(req_q.size[1:0]) - 3'd1)) state_d = RESP;
            else cnt_d = cnt_q + 2'd1;
         end
         WAIT_RX: if (!rx_empty) begin
            rdata_d = {24'h0, rx_head};
            state_d = RESP;
         end
         RESP:    state_d = GAP;
         GAP:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q    <= IDLE;
         req_q      <= '0;
         cnt_q      <= 2'd0;
         rdata_q    <= '0;
         err_q      <= 1'b0;
         rd_empty_q <= 1'b0;
         ctrl_q     <= CTRL_W'(1);
         rx_ovf_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         req_q      <= req_d;
         cnt_q      <= cnt_d;
         rdata_q    <= rdata_d;
         err_q      <= err_d;
         rd_empty_q <= rd_empty_d;
         if (reg_wr && req_q.idx == REG_CTRL) ctrl_q <= req_q.wdata[CTRL_W-1:0] & CTRL_MASK;
         if (ovf_set) rx_ovf_q <= 1'b1;
         else if (reg_wr && req_q.idx == REG_STATUS && req_q.wdata[ST_RX_OVF]) rx_ovf_q <= 1'b0;
      end
   end

`ifdef AHB_UART_IRQ_EN
   logic irq_q;
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) irq_q <= 1'b0;
      else       irq_q <= |({rx_ovf_q, ~rx_empty, tx_empty} & ctrl_q[CTRL_OVF_IE:CTRL_TX_EMPTY_IE]);
   end
   assign irq_o = irq_q;
`endif

   assign bus.hready = (state_q == RESP);
   assign bus.hresp  = (state_q == RESP) & err_q;
   assign bus.hrdata = rdata_q;
endmodule
